// File: rtl/shift_univ_if.sv
// rtl/shift_univ_if.sv - control, data and status bundle for the universal shift register
// Purpose: groups every shift_univ signal except clk/rst.
// Ports (fields):
//   en, mode, sin_msb, sin_lsb, pdata  - manual-mode controls and data (master -> slave)
//   start, dir, nshift                 - burst request (master -> slave)
//   q, sout_r, sout_l, busy, done      - register contents and status (slave -> master)
// Modports: master = driver of the register, slave = the register itself.
interface shift_univ_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic             sin_msb;
    logic             sin_lsb;
    logic [WIDTH-1:0] pdata;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] nshift;
    logic [WIDTH-1:0] q;
    logic             sout_r;
    logic             sout_l;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, sin_msb, sin_lsb, pdata, start, dir, nshift,
        input  q, sout_r, sout_l, busy, done
    );

    modport slave (
        input  en, mode, sin_msb, sin_lsb, pdata, start, dir, nshift,
        output q, sout_r, sout_l, busy, done
    );
endinterface

// File: rtl/shift_univ.sv
// rtl/shift_univ.sv - parametrised universal shift register with counted burst-shift engine
// Purpose: manual hold/shr/shl/load (optional rotate) steps plus an N-step burst shift.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - shift_univ_if.slave: en/mode/sin_msb/sin_lsb/pdata/start/dir/nshift in,
//          q/sout_r/sout_l/busy/done out
// Build option: SHIFT_UNIV_ROTATE_EN enables manual rotate modes 100/101 (hold otherwise).
module shift_univ #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    shift_univ_if.slave bus
);
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A start request always wins over the manual step.
                if (bus.start) begin
                    if (bus.nshift != '0) begin
                        dir_d   = bus.dir;
                        cnt_d   = bus.nshift;
                        state_d = S_BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (bus.en) begin
                    case (bus.mode)
                        M_SHR:   q_d = {bus.sin_msb, q_q[WIDTH-1:1]};
                        M_SHL:   q_d = {q_q[WIDTH-2:0], bus.sin_lsb};
                        M_LOAD:  q_d = bus.pdata;
`ifdef SHIFT_UNIV_ROTATE_EN
                        M_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                        M_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
`endif
                        default: q_d = q_q;
                    endcase
                end
            end
            S_BURST: begin
                // Serial inputs are taken live on each burst edge; bursts never rotate.
                if (dir_q) begin
                    q_d = {q_q[WIDTH-2:0], bus.sin_lsb};
                end else begin
                    q_d = {bus.sin_msb, q_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.q      = q_q;
    assign bus.sout_r = q_q[0];
    assign bus.sout_l = q_q[WIDTH-1];
    assign bus.busy   = (state_q == S_BURST);
    assign bus.done   = done_q;
endmodule
